regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port register file with write-back bypass, a per-register pending-write scoreboard, and a sequential init/clear sweep. It sits in the ID stage of the pipelined core. Read ports serve operand fetch and hazard detection. Write ports are driven by the WB stage(s), and the issue port marks destinations as pending. The array is cleared one row per cycle, so it maps onto RAM-style storage.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of 2, ≥2); AW = clog2(NREG)
- NRD, 2, number of read ports
- NWR, 2, number of write ports; higher index has higher priority
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_clear  in  1  synchronous request to re-initialise array and scoreboard
- o_ready  out  1  high when sweep done and block accepts traffic
- i_rs_addr  in  NRD×AW  read addresses
- o_rs_data  out  NRD×XLEN  read data, combinational
- o_rs_busy  out  NRD  read register has a pending write, combinational
- i_wr_en  in  NWR  write enables
- i_wr_addr  in  NWR×AW  write addresses
- i_wr_data  in  NWR×XLEN  write data
- i_iss_en  in  1  mark i_iss_addr pending
- i_iss_addr  in  AW  destination being issued

## Operation
- FSM states:
  - INIT: sweep counter cnt clears row cnt each cycle.
  - RUN: normal operation.
- Transitions:
  - Async reset → INIT, cnt=0, scoreboard all 0.
  - INIT with cnt==NREG-1 → RUN.
  - RUN with i_clear → INIT, cnt=0, scoreboard cleared.
  - INIT with i_clear → cnt restarts at 0.
- x0 is hardwired: it reads 0, is never busy, and writes and issues to x0 are dropped.
- Writes in RUN: each enabled port with addr≠0 writes its row. When several ports target the same address, the highest-index port wins.
- Read, per port:
  - addr 0 → 0.
  - Otherwise, if any enabled write port matches addr, return the data of the highest-index matching port (bypass).
  - Otherwise return the array row.
- Scoreboard, per row r≠0:
  - Set when i_iss_en && i_iss_addr==r.
  - Cleared when any enabled write port has addr r.
  - Issue and write to the same r in the same cycle → set wins, because the issue is younger.
- o_rs_busy[p] = scoreboard[addr_p] && no enabled write port matches addr_p in this cycle. A same-cycle writeback therefore un-busies the read.
- In INIT:
  - i_wr_en and i_iss_en are ignored.
  - o_rs_data = 0 and o_rs_busy = 0 on all ports.
  - i_clear in RUN drops any same-cycle write or issue.

## Timing
- Reset values: o_ready=0, scoreboard=0; o_rs_data=0 and o_rs_busy=0 while in INIT.
- Sweep takes exactly NREG rising edges. o_ready rises after the NREG-th edge following i_reset deassertion (or following an i_clear edge).
- Reads and busy are zero-latency combinational. A write is visible via bypass in the same cycle and from the array from the next edge.
- Scoreboard updates on the edge; an issue at edge k shows busy from cycle k+1.
- Reset asserted mid-sweep or mid-run restarts from INIT immediately. Array contents are undefined until the sweep completes.

## Structure
- Package regfile_pkg holds:
  - state enum {INIT, RUN}
  - the AW derivation function
  - packed array typedefs for address and data vectors
- Sub-module regfile_scoreboard (NREG bits): set/clear logic, clear input, and per-read-port busy lookup with write-port masking.
- The top level holds the array, the sweep FSM/counter, and the bypass priority muxes.

## Test plan
- Reset release → o_ready=0 for 32 cycles, then 1; every register reads 0; o_rs_busy=0.
- Write 0xDEADBEEF to x5 on port0 while reading x5 → same-cycle o_rs_data=0xDEADBEEF; next cycle the array returns the same value.
- Same cycle, port0 writes x7=0x1 and port1 writes x7=0x2 → read returns 0x2 and x7 holds 0x2 after the edge.
- Issue x9 → busy=1 next cycle. Writeback x9 with a simultaneous read shows busy=0 and the bypassed data. Issuing and writing x9 in the same cycle leaves busy=1.
- Write and issue targeting x0 → reads 0 and busy 0 throughout.
- i_clear after writing x3=0x55 → o_ready=0 for 32 cycles, scoreboard cleared, x3 reads 0. A write attempted during INIT is ignored.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and helpers for the register file
package regfile_pkg;

    function automatic int addr_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = addr_width(NREG_DEF);

    typedef logic [AW_DEF-1:0]   addr_t;
    typedef logic [XLEN_DEF-1:0] data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits with write-masked busy lookup
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = addr_width(NREG)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_iss_en,
    input  logic [AW-1:0]            i_iss_addr,
    input  logic [NWR-1:0]           i_wr_en,
    input  logic [NWR-1:0][AW-1:0]   i_wr_addr,
    input  logic [NRD-1:0][AW-1:0]   i_rs_addr,
    output logic [NRD-1:0]           o_rs_busy
);

    logic [NREG-1:0] sb_q, sb_d;
    logic [NRD-1:0]  wr_hit;

    // Issue is applied after writeback clears: the issuing instruction is younger.
    always_comb begin
        sb_d = sb_q;
        if (i_clear) begin
            sb_d = '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (i_wr_en[w]) begin
                    sb_d[i_wr_addr[w]] = 1'b0;
                end
            end
            if (i_iss_en) begin
                sb_d[i_iss_addr] = 1'b1;
            end
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    always_comb begin
        wr_hit    = '0;
        o_rs_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int w = 0; w < NWR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w] == i_rs_addr[p])) begin
                    wr_hit[p] = 1'b1;
                end
            end
            o_rs_busy[p] = sb_q[i_rs_addr[p]] && !wr_hit[p];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with bypass, scoreboard and row-wise clear sweep
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = addr_width(NREG)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    output logic                     o_ready,
    input  logic [NRD-1:0][AW-1:0]   i_rs_addr,
    output logic [NRD-1:0][XLEN-1:0] o_rs_data,
    output logic [NRD-1:0]           o_rs_busy,
    input  logic [NWR-1:0]           i_wr_en,
    input  logic [NWR-1:0][AW-1:0]   i_wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] i_wr_data,
    input  logic                     i_iss_en,
    input  logic [AW-1:0]            i_iss_addr
);

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [NREG];
    logic            run;
    logic [NWR-1:0]  wr_act;
    logic            iss_act;
    logic [NRD-1:0]  sb_busy;

    assign run     = (state_q == ST_RUN);
    assign o_ready = run;
    // A clear request in RUN drops the same-cycle write and issue traffic.
    assign wr_act  = i_wr_en & {NWR{run && !i_clear}};
    assign iss_act = i_iss_en && run && !i_clear;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (i_clear) begin
                cnt_d = '0;
            end else if (cnt_q == AW'(NREG - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (i_clear) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage has no reset so it can map onto RAM; the sweep zeroes one row per cycle.
    always_ff @(posedge i_clk) begin
        if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_act[w] && (i_wr_addr[w] != '0)) begin
                    mem_q[i_wr_addr[w]] <= i_wr_data[w];
                end
            end
        end
    end

    always_comb begin
        o_rs_data = '0;
        for (int p = 0; p < NRD; p++) begin
            o_rs_data[p] = mem_q[i_rs_addr[p]];
            for (int w = 0; w < NWR; w++) begin
                if (wr_act[w] && (i_wr_addr[w] == i_rs_addr[p])) begin
                    o_rs_data[p] = i_wr_data[w];
                end
            end
            if (!run || (i_rs_addr[p] == '0)) begin
                o_rs_data[p] = '0;
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (i_clear),
        .i_iss_en   (iss_act),
        .i_iss_addr (i_iss_addr),
        .i_wr_en    (wr_act),
        .i_wr_addr  (i_wr_addr),
        .i_rs_addr  (i_rs_addr),
        .o_rs_busy  (sb_busy)
    );

    assign o_rs_busy = sb_busy & {NRD{run}};

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard-checked directed bench for regfile_sb
module tb_regfile_sb;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic             ready;
    logic [1:0][4:0]  rs_addr;
    logic [1:0][31:0] rs_data;
    logic [1:0]       rs_busy;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             iss_en;
    logic [4:0]       iss_addr;

    typedef struct {
        string       name;
        logic        rdy;
        logic [31:0] d0;
        logic        b0;
        logic [31:0] d1;
        logic        b1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_sb dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_clear    (clr),
        .o_ready    (ready),
        .i_rs_addr  (rs_addr),
        .o_rs_data  (rs_data),
        .o_rs_busy  (rs_busy),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".ready"}, {31'd0, ready},      {31'd0, e.rdy});
            chk({e.name, ".data0"}, rs_data[0],          e.d0);
            chk({e.name, ".busy0"}, {31'd0, rs_busy[0]}, {31'd0, e.b0});
            chk({e.name, ".data1"}, rs_data[1],          e.d1);
            chk({e.name, ".busy1"}, {31'd0, rs_busy[1]}, {31'd0, e.b1});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en  = '0;
        iss_en = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic expect_cycle(input string name, input logic rdy,
                                input logic [31:0] d0, input logic b0,
                                input logic [31:0] d1, input logic b1);
        exp_t e;
        e.name = name; e.rdy = rdy; e.d0 = d0; e.b0 = b0; e.d1 = d1; e.b1 = b1;
        exp_q.push_back(e);
    endtask

    task automatic rd(input int a0, input int a1);
        rs_addr[0] = 5'(a0);
        rs_addr[1] = 5'(a1);
    endtask

    task automatic wr(input int port, input int addr, input logic [31:0] data);
        wr_en[port]   = 1'b1;
        wr_addr[port] = 5'(addr);
        wr_data[port] = data;
    endtask

    task automatic iss(input int addr);
        iss_en   = 1'b1;
        iss_addr = 5'(addr);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_en = '0; iss_en = 1'b0;
        wr_addr = '0; wr_data = '0; iss_addr = '0;
        rd(5, 6);

        // reset held, then released: sweep of 32 edges
        tick(); expect_cycle("in_reset", 1'b0, 0, 0, 0, 0);
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            rd(k, 31 - k);
            expect_cycle("sweep", 1'b0, 0, 0, 0, 0);
            tick();
        end
        for (int r = 0; r < 32; r += 2) begin
            rd(r, r + 1);
            expect_cycle("post_reset_read", 1'b1, 0, 0, 0, 0);
            tick();
        end

        // bypass then array read
        rd(5, 5); wr(0, 5, 32'hDEADBEEF);
        expect_cycle("bypass_x5", 1'b1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        tick(); rd(5, 6);
        expect_cycle("array_x5", 1'b1, 32'hDEADBEEF, 0, 0, 0);
        tick();

        // two ports hit x7: port1 wins
        rd(7, 6); wr(0, 7, 32'h1); wr(1, 7, 32'h2);
        expect_cycle("prio_bypass_x7", 1'b1, 32'h2, 0, 0, 0);
        tick(); rd(7, 7);
        expect_cycle("prio_array_x7", 1'b1, 32'h2, 0, 32'h2, 0);
        tick();

        // scoreboard on x9
        rd(9, 9); iss(9);
        expect_cycle("iss_x9_same", 1'b1, 0, 0, 0, 0);
        tick();
        expect_cycle("iss_x9_next", 1'b1, 0, 1, 0, 1);
        tick(); wr(1, 9, 32'h99);
        expect_cycle("wb_x9_unbusy", 1'b1, 32'h99, 0, 32'h99, 0);
        tick();
        expect_cycle("wb_x9_after", 1'b1, 32'h99, 0, 32'h99, 0);
        tick(); iss(9); wr(1, 9, 32'hAA);
        expect_cycle("iss_wb_x9_same", 1'b1, 32'hAA, 0, 32'hAA, 0);
        tick();
        expect_cycle("iss_wb_x9_setwins", 1'b1, 32'hAA, 1, 32'hAA, 1);
        tick(); wr(0, 9, 32'hBB);
        expect_cycle("wb2_x9", 1'b1, 32'hBB, 0, 32'hBB, 0);
        tick();
        expect_cycle("wb2_x9_after", 1'b1, 32'hBB, 0, 32'hBB, 0);
        tick();

        // x0 hardwired
        rd(0, 0); wr(0, 0, 32'h1234); wr(1, 0, 32'h5678); iss(0);
        expect_cycle("x0_same", 1'b1, 0, 0, 0, 0);
        tick();
        expect_cycle("x0_next", 1'b1, 0, 0, 0, 0);
        tick();

        // clear sequence
        rd(3, 4); wr(0, 3, 32'h55); iss(4);
        expect_cycle("pre_clear_wr", 1'b1, 32'h55, 0, 0, 0);
        tick();
        expect_cycle("pre_clear_state", 1'b1, 32'h55, 0, 0, 1);
        tick(); clr = 1'b1; wr(0, 3, 32'h77);
        expect_cycle("clear_cycle", 1'b1, 32'h55, 0, 0, 1);
        tick();
        for (int k = 0; k < 32; k++) begin
            rd(1, 3);
            if (k == 5) begin
                wr(0, 1, 32'h66);
                iss(2);
            end
            expect_cycle("clear_sweep", 1'b0, 0, 0, 0, 0);
            tick();
        end
        rd(1, 3);
        expect_cycle("post_clear_x1_x3", 1'b1, 0, 0, 0, 0);
        tick(); rd(2, 4);
        expect_cycle("post_clear_x2_x4", 1'b1, 0, 0, 0, 0);
        tick();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
